// File: rtl/gemm_top.sv
// Matrix-vector multiply accelerator y = W*x, AXI4-Lite control plus AXI4-Stream data.
// Optional macro GEMM_RELU_EN clamps negative results to zero before output.
module gemm_top #(
  parameter int N = 8
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [3:0]  S_AXIS_TSTRB,
  input  logic        S_AXIS_TLAST,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [3:0]  M_AXIS_TSTRB,
  output logic        M_AXIS_TLAST
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADW = 3'd1,
    S_RECVX = 3'd2,
    S_CALC  = 3'd3,
    S_SEND  = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_live;
  logic            r_bvalid;
  logic            r_rvalid;
  logic [31:0]     r_rdata;
  logic [31:0]     r_cmd;
  logic [DW-1:0]   r_dim;
  logic [IW-1:0]   r_i;
  logic [IW-1:0]   r_j;
  logic [31:0]     r_acc;
  logic [31:0]     r_tdata;
  logic            r_tvalid;
  logic            r_tlast;
  logic [31:0]     r_w [N][N];
  logic [31:0]     r_x [N];
  logic [31:0]     r_y [N];

  logic [DW-1:0]   w_nm1;
  logic [IW-1:0]   w_last;
  logic [IW-1:0]   w_inext;
  logic            w_i_end;
  logic            w_j_end;
  logic            w_wr;
  logic            w_rd;
  logic            w_tready;
  logic            w_s_fire;
  logic [31:0]     w_prod;
  logic [31:0]     w_sum;
  logic [31:0]     w_yval;
  logic [DW-1:0]   w_dim_new;
  logic [31:0]     w_rmux;
  logic            w_unused;

  assign w_nm1    = r_dim - DW'(1);
  assign w_last   = w_nm1[IW-1:0];
  assign w_inext  = r_i + IW'(1);
  assign w_i_end  = (r_i == w_last);
  assign w_j_end  = (r_j == w_last);
  assign w_wr     = S_AXI_AWVALID & S_AXI_WVALID & r_live & ~r_bvalid;
  assign w_rd     = S_AXI_ARVALID & r_live & ~r_rvalid;
  assign w_tready = (r_state == S_LOADW) || (r_state == S_RECVX);
  assign w_s_fire = S_AXIS_TVALID & w_tready;
  assign w_prod   = r_w[r_i][r_j] * r_x[r_j];
  assign w_sum    = r_acc + w_prod;

`ifdef GEMM_RELU_EN
  assign w_yval = w_sum[31] ? '0 : w_sum;
`else
  assign w_yval = w_sum;
`endif

  always_comb begin
    w_dim_new = r_dim;
    if (S_AXI_WDATA == '0)
      w_dim_new = DW'(1);
    else if (S_AXI_WDATA > 32'(N))
      w_dim_new = DW'(N);
    else
      w_dim_new = S_AXI_WDATA[DW-1:0];
  end

  always_comb begin
    w_rmux = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0:    w_rmux = r_cmd;
      2'd1:    w_rmux = {{(32-DW){1'b0}}, r_dim};
      2'd2:    w_rmux = {29'd0, r_state};
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state  <= S_IDLE;
      r_live   <= 1'b0;
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_cmd    <= '0;
      r_dim    <= DW'(N);
      r_i      <= '0;
      r_j      <= '0;
      r_acc    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      r_live <= 1'b1;

      if (w_wr)
        r_bvalid <= 1'b1;
      else if (S_AXI_BREADY)
        r_bvalid <= 1'b0;

      if (w_rd) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rmux;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_wr && S_AXI_AWADDR[3:2] == 2'd0) begin
            r_cmd <= S_AXI_WDATA;
            r_i   <= '0;
            r_j   <= '0;
            if (S_AXI_WDATA == 32'd1)
              r_state <= S_LOADW;
            else if (S_AXI_WDATA == 32'd2)
              r_state <= S_RECVX;
          end else if (w_wr && S_AXI_AWADDR[3:2] == 2'd1) begin
            r_dim <= w_dim_new;
          end
        end
        S_LOADW: begin
          if (w_s_fire) begin
            if (w_j_end) begin
              r_j <= '0;
              if (w_i_end) begin
                r_i     <= '0;
                r_state <= S_IDLE;
              end else begin
                r_i <= w_inext;
              end
            end else begin
              r_j <= r_j + IW'(1);
            end
          end
        end
        S_RECVX: begin
          if (w_s_fire) begin
            if (w_j_end) begin
              r_j     <= '0;
              r_i     <= '0;
              r_acc   <= '0;
              r_state <= S_CALC;
            end else begin
              r_j <= r_j + IW'(1);
            end
          end
        end
        S_CALC: begin
          if (w_j_end) begin
            r_acc <= '0;
            r_j   <= '0;
            if (w_i_end) begin
              r_i     <= '0;
              r_state <= S_SEND;
            end else begin
              r_i <= w_inext;
            end
          end else begin
            r_acc <= w_sum;
            r_j   <= r_j + IW'(1);
          end
        end
        S_SEND: begin
          // First SEND cycle primes the output register; afterwards each handshake preloads the next word.
          if (!r_tvalid) begin
            r_tdata  <= r_y[r_i];
            r_tvalid <= 1'b1;
            r_tlast  <= w_i_end;
          end else if (M_AXIS_TREADY) begin
            if (r_tlast) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_i      <= '0;
              r_state  <= S_IDLE;
            end else begin
              r_tdata <= r_y[w_inext];
              r_tlast <= (w_inext == w_last);
              r_i     <= w_inext;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data storage is deliberately left uninitialised across reset so W survives it.
  always_ff @(posedge S_AXI_ACLK) begin
    if (r_state == S_LOADW && w_s_fire)
      r_w[r_i][r_j] <= S_AXIS_TDATA;
    if (r_state == S_RECVX && w_s_fire)
      r_x[r_j] <= S_AXIS_TDATA;
    if (r_state == S_CALC && w_j_end)
      r_y[r_i] <= w_yval;
  end

  assign S_AXI_AWREADY = r_live & ~r_bvalid;
  assign S_AXI_WREADY  = r_live & ~r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_ARREADY = r_live & ~r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXIS_TREADY = w_tready;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TSTRB  = 4'hF;
  assign M_AXIS_TLAST  = r_tlast;

  assign w_unused = &{1'b0, S_AXI_AWADDR[31:4], S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:4],
                      S_AXI_ARADDR[1:0], S_AXI_WSTRB, S_AXIS_TSTRB, S_AXIS_TLAST, w_nm1};

endmodule

// File: tb/tb_gemm_top.sv
// Self-checking bench for gemm_top: directed cases plus randomized GEMMs against a plain-arithmetic model.
module tb_gemm_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, s_tdata = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic        s_tvalid = 1'b0, m_tready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, s_tready, m_tvalid, m_tlast;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, m_tdata;
  logic [3:0]  m_tstrb;

  gemm_top #(.N(8)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .S_AXIS_TSTRB(4'hF), .S_AXIS_TLAST(1'b0),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
    .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TLAST(m_tlast)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic l; } exp_t;
  exp_t expq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   mw [8][8];
  int   mx [8];
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Output monitor: every accepted word is compared with the head of the expectation queue.
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  exp_t        e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv && !pr) begin
        chk("tvalid_hold", {31'd0, m_tvalid}, 32'd1);
        chk("tdata_hold", m_tdata, pd);
        chk("tlast_hold", {31'd0, m_tlast}, {31'd0, pl});
      end
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got %h expected none", m_tdata);
        end else begin
          e = expq.pop_front();
          chk("y_data", m_tdata, e.d);
          chk("y_last", {31'd0, m_tlast}, {31'd0, e.l});
          chk("tstrb", {28'd0, m_tstrb}, 32'hF);
        end
      end
    end
    pv = m_tvalid && rst_n;
    pr = m_tready;
    pd = m_tdata;
    pl = m_tlast;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic void push_model(input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      int acc = 0;
      for (int j = 0; j < n; j++) acc += mw[i][j] * mx[j];
`ifdef GEMM_RELU_EN
      if (acc < 0) acc = 0;
`endif
      x.d = acc;
      x.l = (i == n - 1);
      expq.push_back(x);
    end
  endfunction

  function automatic void push_lit(input logic [31:0] d, input logic l);
    exp_t x;
    x.d = d;
    x.l = l;
    expq.push_back(x);
  endfunction

  function automatic int rnd_word();
    if ($urandom_range(0, 2) != 0) return int'($urandom_range(0, 200)) - 100;
    return int'($urandom);
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    int k;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!(awready && wready) && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) tmo("aw_ready");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!bvalid && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) tmo("bvalid");
    else chk("bresp", {30'd0, bresp}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d);
    int k;
    araddr = addr; arvalid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!arready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) tmo("ar_ready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!rvalid && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) tmo("rvalid");
    d = rdata;
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] data);
    int k;
    s_tdata = data; s_tvalid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!s_tready && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) tmo("s_tready");
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic load_w(input int n);
    axi_write(32'h0, 32'd1);
    for (int k = 0; k < n * n; k++) send_word(mw[k / n][k % n]);
  endtask

  task automatic start_gemm(input int n);
    axi_write(32'h0, 32'd2);
    for (int j = 0; j < n; j++) send_word(mx[j]);
  endtask

  task automatic drain(input string name);
    int k;
    logic [31:0] d;
    k = 0;
    @(negedge clk);
    while ((expq.size() != 0 || m_tvalid) && k < 3000) begin @(negedge clk); k++; end
    if (k >= 3000) tmo(name);
    @(posedge clk); #1;
    axi_read(32'h8, d);
    chk("status_idle", d, 32'd0);
    chk("s_tready_idle", {31'd0, s_tready}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(32'h8, d); chk("status_reset", d, 32'd0);
    axi_read(32'h4, d); chk("dim_reset", d, 32'd8);

    // Identity 4x4
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) mw[i][j] = 0;
    for (int i = 0; i < 4; i++) mw[i][i] = 1;
    axi_write(32'h4, 32'd4);
    load_w(4);
    for (int j = 0; j < 4; j++) mx[j] = j + 1;
    start_gemm(4);
    push_lit(32'd1, 1'b0); push_lit(32'd2, 1'b0); push_lit(32'd3, 1'b0); push_lit(32'd4, 1'b1);
    drain("drain_identity");

    // 2x2 of 2s, with CMD=2 attempted mid-load
    axi_write(32'h4, 32'd2);
    mw[0][0] = 2; mw[0][1] = 2; mw[1][0] = 2; mw[1][1] = 2;
    axi_write(32'h0, 32'd1);
    send_word(32'd2);
    axi_write(32'h0, 32'd2);
    axi_read(32'h8, d); chk("status_loadw_hold", d, 32'd1);
    for (int k = 0; k < 3; k++) send_word(32'd2);
    axi_read(32'h8, d); chk("status_after_load", d, 32'd0);
    mx[0] = 3; mx[1] = -1;
    start_gemm(2);
    push_lit(32'd4, 1'b0); push_lit(32'd4, 1'b1);
    drain("drain_2x2_pos");
    mx[0] = -3; mx[1] = 1;
    start_gemm(2);
`ifdef GEMM_RELU_EN
    push_lit(32'd0, 1'b0); push_lit(32'd0, 1'b1);
`else
    push_lit(32'hFFFF_FFFC, 1'b0); push_lit(32'hFFFF_FFFC, 1'b1);
`endif
    drain("drain_2x2_neg");

    // 1x1 wraparound
    axi_write(32'h4, 32'd1);
    mw[0][0] = 32'h0001_0000;
    load_w(1);
    mx[0] = 32'h0001_0000;
    start_gemm(1);
    push_lit(32'd0, 1'b1);
    drain("drain_wrap");

    axi_write(32'h4, 32'd0);  axi_read(32'h4, d); chk("dim_clamp_lo", d, 32'd1);
    axi_write(32'h4, 32'd99); axi_read(32'h4, d); chk("dim_clamp_hi", d, 32'd8);
    axi_read(32'hC, d); chk("reg_c_zero", d, 32'd0);

    // Full 8x8 with alternating output backpressure
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) mw[i][j] = rnd_word();
    load_w(8);
    for (int j = 0; j < 8; j++) mx[j] = rnd_word();
    rdy_mode = 1;
    start_gemm(8);
    push_model(8);
    drain("drain_toggle");
    rdy_mode = 0;

    // Reset during CALC, then reuse the retained W
    for (int j = 0; j < 8; j++) mx[j] = rnd_word();
    start_gemm(8);
    repeat (5) @(posedge clk);
    #1;
    axi_read(32'h8, d); chk("status_calc", d, 32'd3);
    rst_n = 1'b0;
    #2;
    chk("abort_tvalid", {31'd0, m_tvalid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(32'h8, d); chk("status_abort", d, 32'd0);
    for (int j = 0; j < 8; j++) mx[j] = rnd_word();
    start_gemm(8);
    push_model(8);
    drain("drain_after_reset");

    // Randomized dimensions, weights and backpressure
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 8);
      axi_write(32'h4, 32'(n));
      if (it == 0 || $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) for (int j = 0; j < n; j++) mw[i][j] = rnd_word();
        load_w(n);
      end
      for (int j = 0; j < n; j++) mx[j] = rnd_word();
      rdy_mode = $urandom_range(0, 2);
      start_gemm(n);
      push_model(n);
      drain("drain_random");
      rdy_mode = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
